pipa_moding_encoder: RTL and testbench
======================================

Name: pipa_moding_encoder

Overview:
- Accelerometer-side responder for the AGC PIPA interface.
- Consumes the AGC's PIPASW slot strobe and PIPDAT data strobe and drives the six PIPA pulse lines (PIPAXp/m, PIPAYp/m, PIPAZp/m) using 3-3 ternary moding.
- Per-axis commanded net counts are accumulated with a residual, so non-even or fractional rates average out exactly over frames.
- Sits in the simulation/FPGA top level between the AGC and the test environment. It replaces ad-hoc PIPA spoofing.

Parameters:
- RATE_W, 8, width of signed per-frame rate inputs.
- RES_W, 12, width of signed per-axis residual accumulator.

Ports:
- SIM_CLK  input  1  system clock.
- SIM_RST_n  input  1  reset, synchronous, active-low.
- ENABLE  input  1  1 = generate pulses; 0 = idle.
- PIPASW  input  1  AGC slot strobe; a rising edge advances the slot.
- PIPDAT  input  1  AGC data strobe; its level is gated to the outputs.
- RATEX, RATEY, RATEZ  input  RATE_W  signed commanded net pulses (plus minus minus) per frame.
- PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  output  1  PIPA pulse lines.
- FRAME  output  1  one-cycle pulse on each frame boundary.
- SLOT  output  3  current slot index, 0..5.
- SATX, SATY, SATZ  output  1  sticky residual-saturation flags.

Behaviour:
- Reset (SIM_RST_n=0 at a SIM_CLK edge):
  - SLOT=0, all residuals R=0, all plus-counts p=3.
  - All PIPA outputs, FRAME and SAT flags =0.
  - The PIPASW edge-detect register is cleared to 0.
  - Reset mid-frame discards the frame; no partial pulses follow.
- PIPASW rising edge: detected as PIPASW=1 with the previous registered value 0, sampled on SIM_CLK.
  - SLOT<5: SLOT increments.
  - SLOT=5: SLOT wraps to 0, this is a frame boundary, and FRAME pulses for 1 cycle on the following clock.
- Frame boundary, per axis, computed in one cycle using the RATE sampled on the boundary cycle:
  - R' = sat_RES_W(R + sign-extended RATE).
  - q = R'/2 truncated toward zero, clamped to [-3,+3].
  - p = 3 + q.
  - R = R' - 2q.
  - If R + RATE overflows RES_W, R' saturates to +/-(2^(RES_W-1)-1) and SATx sets; SATx clears only on reset.
- Slot polarity: slots 0..p-1 are plus slots; slots p..5 are minus slots. Net per frame = 2p-6.
- Outputs, registered with 1-cycle latency:
  - PIPAxp <= ENABLE & PIPDAT & (slot_next < p_next).
  - PIPAxm <= ENABLE & PIPDAT & (slot_next >= p_next).
  - slot_next and p_next are the values in effect after the current cycle's update, so a PIPASW edge coincident with PIPDAT uses the new slot.
  - At most one of p/m per axis is high in any cycle.
- ENABLE=0: all PIPA outputs are held 0. SLOT and edge detection keep tracking PIPASW. Residuals still update at frame boundaries, but with RATE treated as 0.
- ENABLE 0->1 mid-frame: pulses resume at the current slot using the current p.
- Boundary values: RATE=-128 is legal. p=0 gives all minus slots; p=6 gives all plus slots.
- A PIPDAT level held across multiple cycles yields an output held for the same number of cycles.

Decomposition:
- Shared package pipa_pkg:
  - SLOTS_PER_FRAME=6, NOMINAL_P=3, QMAX=3.
  - slot_t (3-bit) and residual saturation limit constants.
- One sub-module, pipa_axis_mod, instantiated 3 times. It holds the residual accumulator, the p computation, the SAT flag and the p/m output registers, taking slot_next, frame_tick, ENABLE, PIPDAT and RATE.
- The top level owns PIPASW edge detection, the slot counter and FRAME.

Test Plan:
- Reset then RATE=0, 12 PIPASW edges each followed by one PIPDAT pulse -> per axis p pulses in slots 0,1,2 and m pulses in slots 3,4,5; FRAME pulses twice; net 0.
- RATEX=+4 held -> every frame after the first boundary gives 5 PIPAXp + 1 PIPAXm; R stays 0.
- RATEY=+1 held -> alternating frames of p=3 and p=4; net +2 every 2 frames; R alternates 1,0.
- RATEZ=+10 held with RES_W=12 -> p=6 every frame; R grows by 4 per frame; SATZ sets when R reaches 2047 and stays set.
- PIPASW edge coincident with PIPDAT at slot 2->3, RATE=0 -> PIPAxm asserts (not PIPAxp) 1 cycle later; ENABLE=0 -> all six outputs stay 0 while SLOT still advances.
- Assert SIM_RST_n=0 at slot 4 -> next cycle SLOT=0, outputs 0, SAT flags clear, next frame is nominal 3-3.

Source files
------------

// File: rtl/pipa_pkg.sv
// Shared constants and types for the PIPA 3-3 ternary moding encoder.
package pipa_pkg;

  localparam int SLOTS_PER_FRAME = 6;
  localparam int NOMINAL_P       = 3;
  localparam int QMAX            = 3;
  localparam int RES_W_DEF       = 12;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_LAST = slot_t'(SLOTS_PER_FRAME - 1);

  // Largest magnitude a residual of the given width may hold (symmetric range).
  function automatic int res_limit(input int res_w);
    return (1 << (res_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pipa_axis_mod.sv
// One PIPA axis: residual accumulator, plus-slot count p, sticky saturation
// flag and the registered plus/minus pulse lines.
module pipa_axis_mod
  import pipa_pkg::*;
#(
  parameter int RATE_W = 8,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              pipdat,
  input  logic              frame_tick,
  input  logic [2:0]        slot_next,
  input  logic [RATE_W-1:0] rate,
  output logic              pipa_p,
  output logic              pipa_m,
  output logic              sat
);

  localparam int                      RES_MAX = res_limit(RES_W);
  localparam logic signed [RES_W:0]   SUM_HI  = (RES_W+1)'(RES_MAX);
  localparam logic signed [RES_W:0]   SUM_LO  = (RES_W+1)'(-RES_MAX - 1);
  localparam logic signed [RES_W-1:0] R_HI    = RES_W'(RES_MAX);
  localparam logic signed [RES_W-1:0] R_LO    = RES_W'(-RES_MAX);
  localparam logic signed [RES_W-1:0] Q_HI    = RES_W'(QMAX);
  localparam logic signed [RES_W-1:0] Q_LO    = RES_W'(-QMAX);
  localparam logic signed [3:0]       Q4_HI   = 4'(QMAX);
  localparam logic signed [3:0]       Q4_LO   = 4'(-QMAX);

  function automatic logic signed [RES_W-1:0] sat_res(input logic signed [RES_W:0] s);
    if (s > SUM_HI)      return R_HI;
    else if (s < SUM_LO) return R_LO;
    else                 return s[RES_W-1:0];
  endfunction

  // Halve toward zero (arithmetic shift floors, so bump negative odd values)
  // then clamp to the +/-QMAX moding range.
  function automatic logic signed [3:0] half_clamp(input logic signed [RES_W-1:0] r);
    logic signed [RES_W-1:0] h;
    h = (r >>> 1) + $signed({{(RES_W-1){1'b0}}, r[RES_W-1] & r[0]});
    if (h > Q_HI)      return Q4_HI;
    else if (h < Q_LO) return Q4_LO;
    else               return h[3:0];
  endfunction

  logic signed [RES_W-1:0] res_q, res_d;
  logic        [2:0]       p_q, p_d;
  logic                    sat_q, sat_d;
  logic                    pp_q, pp_d;
  logic                    pm_q, pm_d;

  logic signed [RES_W:0]   rate_ext;
  logic signed [RES_W:0]   sum;
  logic                    ovf;
  logic signed [RES_W-1:0] r_sat;
  logic signed [3:0]       q;
  logic        [2:0]       p_new;
  logic signed [RES_W-1:0] res_new;

  always_comb begin
    rate_ext = '0;
    if (enable) rate_ext = {{(RES_W+1-RATE_W){rate[RATE_W-1]}}, rate};
    sum     = {res_q[RES_W-1], res_q} + rate_ext;
    ovf     = (sum > SUM_HI) || (sum < SUM_LO);
    r_sat   = sat_res(sum);
    q       = half_clamp(r_sat);
    p_new   = 3'(NOMINAL_P) + q[2:0];
    res_new = r_sat - ({{(RES_W-4){q[3]}}, q} <<< 1);

    res_d = res_q;
    p_d   = p_q;
    sat_d = sat_q;
    if (frame_tick) begin
      res_d = res_new;
      p_d   = p_new;
      sat_d = sat_q | ovf;
    end

    // Polarity uses the post-update slot and p so a coincident edge takes effect at once.
    pp_d = enable & pipdat & (slot_next <  p_d);
    pm_d = enable & pipdat & (slot_next >= p_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      p_q   <= 3'(NOMINAL_P);
      sat_q <= 1'b0;
      pp_q  <= 1'b0;
      pm_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      p_q   <= p_d;
      sat_q <= sat_d;
      pp_q  <= pp_d;
      pm_q  <= pm_d;
    end
  end

  assign pipa_p = pp_q;
  assign pipa_m = pm_q;
  assign sat    = sat_q;

endmodule

// File: rtl/pipa_moding_encoder.sv
// AGC PIPA responder: tracks PIPASW slot edges, marks frame boundaries and
// drives three ternary-moded axes from per-frame commanded rates.
module pipa_moding_encoder
  import pipa_pkg::*;
#(
  parameter int RATE_W = 8,
  parameter int RES_W  = RES_W_DEF
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST_n,
  input  logic              ENABLE,
  input  logic              PIPASW,
  input  logic              PIPDAT,
  input  logic [RATE_W-1:0] RATEX,
  input  logic [RATE_W-1:0] RATEY,
  input  logic [RATE_W-1:0] RATEZ,
  output logic              PIPAXp,
  output logic              PIPAXm,
  output logic              PIPAYp,
  output logic              PIPAYm,
  output logic              PIPAZp,
  output logic              PIPAZm,
  output logic              FRAME,
  output logic [2:0]        SLOT,
  output logic              SATX,
  output logic              SATY,
  output logic              SATZ
);

  logic  pipasw_q, pipasw_d;
  slot_t slot_q, slot_d;
  logic  frame_q, frame_d;
  logic  rise;
  logic  frame_tick;

  always_comb begin
    pipasw_d   = PIPASW;
    rise       = PIPASW & ~pipasw_q;
    frame_tick = rise & (slot_q == SLOT_LAST);
    slot_d     = slot_q;
    if (frame_tick)  slot_d = '0;
    else if (rise)   slot_d = slot_q + 3'd1;
    frame_d    = frame_tick;
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST_n) begin
      pipasw_q <= 1'b0;
      slot_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      pipasw_q <= pipasw_d;
      slot_q   <= slot_d;
      frame_q  <= frame_d;
    end
  end

  assign SLOT  = slot_q;
  assign FRAME = frame_q;

  pipa_axis_mod #(.RATE_W(RATE_W), .RES_W(RES_W)) u_axis_x (
    .clk        (SIM_CLK),
    .rst_n      (SIM_RST_n),
    .enable     (ENABLE),
    .pipdat     (PIPDAT),
    .frame_tick (frame_tick),
    .slot_next  (slot_d),
    .rate       (RATEX),
    .pipa_p     (PIPAXp),
    .pipa_m     (PIPAXm),
    .sat        (SATX)
  );

  pipa_axis_mod #(.RATE_W(RATE_W), .RES_W(RES_W)) u_axis_y (
    .clk        (SIM_CLK),
    .rst_n      (SIM_RST_n),
    .enable     (ENABLE),
    .pipdat     (PIPDAT),
    .frame_tick (frame_tick),
    .slot_next  (slot_d),
    .rate       (RATEY),
    .pipa_p     (PIPAYp),
    .pipa_m     (PIPAYm),
    .sat        (SATY)
  );

  pipa_axis_mod #(.RATE_W(RATE_W), .RES_W(RES_W)) u_axis_z (
    .clk        (SIM_CLK),
    .rst_n      (SIM_RST_n),
    .enable     (ENABLE),
    .pipdat     (PIPDAT),
    .frame_tick (frame_tick),
    .slot_next  (slot_d),
    .rate       (RATEZ),
    .pipa_p     (PIPAZp),
    .pipa_m     (PIPAZm),
    .sat        (SATZ)
  );

endmodule

// File: tb/tb_pipa_moding_encoder.sv
// Bench for pipa_moding_encoder: fixed vector table, hand sequences for
// multi-frame corners, and randomized traffic against an integer model.
module tb_pipa_moding_encoder;

  localparam int RATE_W = 8;
  localparam int RES_W  = 12;

  logic              SIM_CLK = 1'b0;
  logic              SIM_RST_n, ENABLE, PIPASW, PIPDAT;
  logic [RATE_W-1:0] RATEX, RATEY, RATEZ;
  logic              PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
  logic              FRAME;
  logic [2:0]        SLOT;
  logic              SATX, SATY, SATZ;

  always #5 SIM_CLK = ~SIM_CLK;

  pipa_moding_encoder #(.RATE_W(RATE_W), .RES_W(RES_W)) dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST_n (SIM_RST_n),
    .ENABLE    (ENABLE),
    .PIPASW    (PIPASW),
    .PIPDAT    (PIPDAT),
    .RATEX     (RATEX),
    .RATEY     (RATEY),
    .RATEZ     (RATEZ),
    .PIPAXp    (PIPAXp),
    .PIPAXm    (PIPAXm),
    .PIPAYp    (PIPAYp),
    .PIPAYm    (PIPAYm),
    .PIPAZp    (PIPAZp),
    .PIPAZm    (PIPAZm),
    .FRAME     (FRAME),
    .SLOT      (SLOT),
    .SATX      (SATX),
    .SATY      (SATY),
    .SATZ      (SATZ)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers following the frame rules.
  bit m_sw;
  int m_slot;
  int m_r[3];
  int m_p[3];
  bit m_sat[3];
  bit m_frame;
  bit m_pp[3];
  bit m_pm[3];
  int cnt_p[3];
  int cnt_m[3];

  typedef struct {
    bit       rst_n;
    bit       sw;
    bit       dat;
    bit       en;
    bit [2:0] slot;
    bit       frame;
    bit [5:0] pipa;
  } vec_t;

  vec_t tbl[$];

  localparam bit [5:0] PLUS  = 6'b101010;
  localparam bit [5:0] MINUS = 6'b010101;
  localparam bit [5:0] NONE  = 6'b000000;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, got, exp);
    end
  endtask

  function automatic int rate_of(input int ax);
    case (ax)
      0:       return int'($signed(RATEX));
      1:       return int'($signed(RATEY));
      default: return int'($signed(RATEZ));
    endcase
  endfunction

  task automatic model_step(input bit rst_n_i, input bit sw, input bit dat, input bit en);
    int lim;
    int r;
    int q;
    bit rise;
    lim = (1 << (RES_W - 1)) - 1;
    if (!rst_n_i) begin
      m_sw    = 1'b0;
      m_slot  = 0;
      m_frame = 1'b0;
      for (int a = 0; a < 3; a++) begin
        m_r[a] = 0; m_p[a] = 3; m_sat[a] = 1'b0; m_pp[a] = 1'b0; m_pm[a] = 1'b0;
      end
      return;
    end
    rise    = sw && !m_sw;
    m_sw    = sw;
    m_frame = 1'b0;
    if (rise) begin
      if (m_slot == 5) begin
        m_slot  = 0;
        m_frame = 1'b1;
        for (int a = 0; a < 3; a++) begin
          r = m_r[a] + (en ? rate_of(a) : 0);
          if (r > lim) begin
            r = lim; m_sat[a] = 1'b1;
          end else if (r < -lim - 1) begin
            r = -lim; m_sat[a] = 1'b1;
          end
          q = r / 2;
          if (q > 3)  q = 3;
          if (q < -3) q = -3;
          m_p[a] = 3 + q;
          m_r[a] = r - 2 * q;
        end
      end else begin
        m_slot = m_slot + 1;
      end
    end
    for (int a = 0; a < 3; a++) begin
      m_pp[a] = en && dat && (m_slot <  m_p[a]);
      m_pm[a] = en && dat && (m_slot >= m_p[a]);
    end
  endtask

  task automatic cyc(input bit rst_n_i, input bit sw, input bit dat, input bit en);
    logic [12:0] got;
    logic [12:0] exp;
    SIM_RST_n = rst_n_i;
    PIPASW    = sw;
    PIPDAT    = dat;
    ENABLE    = en;
    model_step(rst_n_i, sw, dat, en);
    @(posedge SIM_CLK);
    #1;
    got = {PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm, FRAME, SLOT, SATX, SATY, SATZ};
    exp = {m_pp[0], m_pm[0], m_pp[1], m_pm[1], m_pp[2], m_pm[2], m_frame, 3'(m_slot),
           m_sat[0], m_sat[1], m_sat[2]};
    check("model", 32'(got), 32'(exp));
    cnt_p[0] += int'(PIPAXp); cnt_m[0] += int'(PIPAXm);
    cnt_p[1] += int'(PIPAYp); cnt_m[1] += int'(PIPAYm);
    cnt_p[2] += int'(PIPAZp); cnt_m[2] += int'(PIPAZm);
  endtask

  task automatic clear_counts();
    for (int a = 0; a < 3; a++) begin
      cnt_p[a] = 0; cnt_m[a] = 0;
    end
  endtask

  // One frame: a data pulse in each slot, then the edge that leaves it.
  task automatic frame_run();
    for (int s = 0; s < 6; s++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic fast_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int s = 0; s < 6; s++) begin
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  task automatic push(input bit r, input bit sw, input bit dat, input bit en,
                      input int slot, input bit fr, input bit [5:0] pipa);
    vec_t v;
    v.rst_n = r; v.sw = sw; v.dat = dat; v.en = en;
    v.slot = 3'(slot); v.frame = fr; v.pipa = pipa;
    tbl.push_back(v);
  endtask

  initial begin
    SIM_RST_n = 1'b0; ENABLE = 1'b0; PIPASW = 1'b0; PIPDAT = 1'b0;
    RATEX = '0; RATEY = '0; RATEZ = '0;
    clear_counts();

    // Nominal 3-3 moding over two frames, then coincident edge and ENABLE gating.
    push(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, NONE);
    for (int i = 0; i < 12; i++) begin
      int s;
      s = i % 6;
      push(1'b1, 1'b0, 1'b1, 1'b1, s, 1'b0, (s < 3) ? PLUS : MINUS);
      push(1'b1, 1'b1, 1'b0, 1'b1, (s + 1) % 6, (s == 5), NONE);
      push(1'b1, 1'b0, 1'b0, 1'b1, (s + 1) % 6, 1'b0, NONE);
    end
    push(1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, NONE);
    push(1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, NONE);
    push(1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0, NONE);
    push(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, NONE);
    push(1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b0, MINUS);
    push(1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, NONE);
    push(1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, NONE);
    push(1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b0, NONE);
    push(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, NONE);
    push(1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0, NONE);
    push(1'b1, 1'b0, 1'b1, 1'b1, 5, 1'b0, MINUS);
    push(1'b1, 1'b0, 1'b0, 1'b1, 5, 1'b0, NONE);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst_n, tbl[i].sw, tbl[i].dat, tbl[i].en);
      check($sformatf("table[%0d]", i),
            32'({PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm, FRAME, SLOT}),
            32'({tbl[i].pipa, tbl[i].frame, tbl[i].slot}));
    end

    // RATEX=+4 and RATEY=+1: 5/1 on X every frame, Y alternating 3 and 4 plus slots.
    RATEX = 8'sd4; RATEY = 8'sd1; RATEZ = '0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    frame_run();
    clear_counts();
    frame_run();
    check("x_plus_f1", 32'(cnt_p[0]), 32'd5);
    check("x_minus_f1", 32'(cnt_m[0]), 32'd1);
    check("y_plus_f1", 32'(cnt_p[1]), 32'd3);
    clear_counts();
    frame_run();
    check("x_plus_f2", 32'(cnt_p[0]), 32'd5);
    check("y_plus_f2", 32'(cnt_p[1]), 32'd4);
    check("y_minus_f2", 32'(cnt_m[1]), 32'd2);

    // RATEZ=+10: p=6 and residual grows 4 per frame until it pins at the limit.
    RATEX = '0; RATEY = '0; RATEZ = 8'sd10;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    clear_counts();
    frame_run();
    frame_run();
    clear_counts();
    frame_run();
    check("z_all_plus", 32'(cnt_p[2]), 32'd6);
    check("z_no_minus", 32'(cnt_m[2]), 32'd0);
    fast_frames(507);
    check("satz_before", 32'(SATZ), 32'd0);
    fast_frames(1);
    check("satz_set", 32'(SATZ), 32'd1);
    fast_frames(4);
    check("satz_sticky", 32'(SATZ), 32'd1);
    check("satx_clear", 32'(SATX), 32'd0);

    // Reset at slot 4 clears everything and the next frame is nominal.
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
    end
    check("slot_before_rst", 32'(SLOT), 32'd4);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("after_rst",
          32'({PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm, FRAME, SLOT, SATX, SATY, SATZ}),
          32'd0);
    RATEZ = '0;
    clear_counts();
    frame_run();
    check("z_plus_nominal", 32'(cnt_p[2]), 32'd3);
    check("z_minus_nominal", 32'(cnt_m[2]), 32'd3);

    // Randomized traffic, including RATE=-128 and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) RATEX = RATE_W'($urandom);
      if ($urandom_range(0, 31) == 0) RATEY = RATE_W'($urandom);
      if ($urandom_range(0, 31) == 0) RATEZ = RATE_W'($urandom);
      if ($urandom_range(0, 63) == 0) RATEX = 8'h80;
      cyc($urandom_range(0, 499) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
